// File: rtl/cpu_cluster_ctrl_if.sv
// Register port of the hart-cluster controller.
//   req   : access strobe, sampled on the rising clock edge
//   we    : 1 = write, 0 = read
//   addr  : byte address, [7:4] hart index, [3:2] register select
//   wdata : write data
//   rdata : read data, valid while ready is high
//   ready : completion, high the cycle after the request
// master = fabric side, slave = controller side.
interface cpu_cluster_ctrl_if;
  logic        req;
  logic        we;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/cpu_cluster_ctrl.sv
// Hart-cluster controller: per-hart reset sequencing, boot address,
// synchronised and masked interrupt/debug delivery and software IPIs.
// Optional feature macro: CPU_CLUSTER_IPI_EN (IPI pending state, CTRL
// bits 2/3, STATUS bit 2). Without it hart_ipi_o is tied low.
//
// Ports (top):
//   clk_i, rst_ni       clock, async active-low reset
//   boot_addr_i         strapped default boot address
//   reg_if              register port (slave modport)
//   irq_i/time_irq_i/debug_req_i        async inputs, per hart
//   hart_rst_no/hart_boot_addr_o/hart_irq_o/hart_time_irq_o/
//   hart_ipi_o/hart_debug_req_o          per-hart outputs
//
// cpu_cluster_hart holds everything belonging to one hart.

module cpu_cluster_hart #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_DLY     = 16,
  parameter bit          BOOT_HART   = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        arm_i,
  input  logic [63:0] boot_addr_i,
  input  logic        wr_baddr_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_mask_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  irq_i,
  input  logic        time_irq_i,
  input  logic        debug_req_i,
  output logic [63:0] eff_addr_o,
  output logic [2:0]  mask_o,
  output logic [6:0]  status_o,
  output logic        rst_no,
  output logic [63:0] boot_addr_o,
  output logic [1:0]  irq_o,
  output logic        time_irq_o,
  output logic        ipi_o,
  output logic        debug_req_o
);
  typedef enum logic [1:0] {ST_OFF = 2'd0, ST_BOOT = 2'd1, ST_RUN = 2'd2} state_e;

  localparam logic [7:0] DLY_M1 = 8'(RST_DLY - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        rst_q;
  logic [63:0] breg_q, bout_q;
  logic        written_q, bld_q;
  logic [2:0]  mask_q;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]  synced;
  logic [1:0]  irq_q;
  logic        tim_q, dbg_q;
  logic        start, halt, run;

  assign start      = wr_ctrl_i & wdata_i[0];
  assign halt       = wr_ctrl_i & wdata_i[1];
  assign run        = (state_q == ST_RUN);
  assign eff_addr_o = written_q ? breg_q : boot_addr_i;
  assign mask_o     = mask_q;
  assign synced     = sync_q[SYNC_STAGES-1];

  // {debug, timer, irq1, irq0} travel through one shared chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], {debug_req_i, time_irq_i, irq_i}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      breg_q    <= '0;
      written_q <= 1'b0;
      mask_q    <= 3'b111;
    end else begin
      if (wr_baddr_i) begin
        breg_q    <= wdata_i;
        written_q <= 1'b1;
      end
      if (wr_mask_i) mask_q <= wdata_i[2:0];
    end
  end

  // rst_q tracks the next state so the release lands on the same edge
  // the FSM enters RUN; arm_i holds the counter on the first edge after
  // reset so the boot hart sees the same delay as a START write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT_HART ? ST_BOOT : ST_OFF;
      cnt_q   <= '0;
      rst_q   <= 1'b0;
      bout_q  <= '0;
      bld_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: if (start) begin
          state_q <= ST_BOOT;
          cnt_q   <= '0;
          bout_q  <= eff_addr_o;
          bld_q   <= 1'b1;
        end
        ST_BOOT: begin
          if (halt && !start) state_q <= ST_OFF;
          else if (arm_i) begin
            if (cnt_q == DLY_M1) begin
              state_q <= ST_RUN;
              rst_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ST_RUN: if (halt) begin
          rst_q <= 1'b0;
          cnt_q <= '0;
          if (start) begin
            state_q <= ST_BOOT;
            bout_q  <= eff_addr_o;
            bld_q   <= 1'b1;
          end else begin
            state_q <= ST_OFF;
          end
        end
        default: begin
          state_q <= ST_OFF;
          rst_q   <= 1'b0;
        end
      endcase
    end
  end

  // Gating uses the registered state, so a HALT clears these one edge later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= '0;
      tim_q <= 1'b0;
      dbg_q <= 1'b0;
    end else begin
      irq_q <= synced[1:0] & mask_q[1:0] & {2{run}};
      tim_q <= synced[2] & mask_q[2] & run;
      dbg_q <= synced[3] & run;
    end
  end

`ifdef CPU_CLUSTER_IPI_EN
  logic pend_q;
  // Clear wins over set; any HALT in RUN leaves RUN and drops the IPI
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        pend_q <= 1'b0;
    else if ((wr_ctrl_i && wdata_i[3]) || (run && halt)) pend_q <= 1'b0;
    else if (wr_ctrl_i && wdata_i[2] && run)            pend_q <= 1'b1;
  end
  assign ipi_o = pend_q;
`else
  assign ipi_o = 1'b0;
`endif

  // Before any BOOT entry the boot hart presents the strap directly
  assign boot_addr_o = (BOOT_HART && !bld_q) ? boot_addr_i : bout_q;
  assign rst_no      = rst_q;
  assign irq_o       = irq_q;
  assign time_irq_o  = tim_q;
  assign debug_req_o = dbg_q;
  assign status_o    = {synced, ipi_o, state_q};
endmodule

module cpu_cluster_ctrl #(
  parameter int unsigned NUM_HARTS   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_DLY     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [63:0]                   boot_addr_i,
  cpu_cluster_ctrl_if.slave             reg_if,
  input  logic [2*NUM_HARTS-1:0]        irq_i,
  input  logic [NUM_HARTS-1:0]          time_irq_i,
  input  logic [NUM_HARTS-1:0]          debug_req_i,
  output logic [NUM_HARTS-1:0]          hart_rst_no,
  output logic [NUM_HARTS-1:0][63:0]    hart_boot_addr_o,
  output logic [2*NUM_HARTS-1:0]        hart_irq_o,
  output logic [NUM_HARTS-1:0]          hart_time_irq_o,
  output logic [NUM_HARTS-1:0]          hart_ipi_o,
  output logic [NUM_HARTS-1:0]          hart_debug_req_o
);
  logic [3:0]  hidx;
  logic [1:0]  sel;
  logic        wr_en;
  logic        arm_q;
  logic        ready_q;
  logic [63:0] rdata_q, rd_mux;
  logic        unused_addr;

  logic [NUM_HARTS-1:0][63:0] eff_addr;
  logic [NUM_HARTS-1:0][2:0]  mask;
  logic [NUM_HARTS-1:0][6:0]  status;

  assign hidx        = reg_if.addr[7:4];
  assign sel         = reg_if.addr[3:2];
  assign wr_en       = reg_if.req & reg_if.we;
  assign unused_addr = ^reg_if.addr[1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) arm_q <= 1'b0;
    else         arm_q <= 1'b1;
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    // hidx only ever matches an existing hart, so out-of-range
    // accesses fall through with no strobe and a zero read
    logic hit;
    assign hit = wr_en && (hidx == 4'(h));

    cpu_cluster_hart #(
      .SYNC_STAGES(SYNC_STAGES),
      .RST_DLY    (RST_DLY),
      .BOOT_HART  (h == 0)
    ) u_hart (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .arm_i      (arm_q),
      .boot_addr_i(boot_addr_i),
      .wr_baddr_i (hit && sel == 2'd0),
      .wr_ctrl_i  (hit && sel == 2'd1),
      .wr_mask_i  (hit && sel == 2'd2),
      .wdata_i    (reg_if.wdata),
      .irq_i      (irq_i[2*h+1:2*h]),
      .time_irq_i (time_irq_i[h]),
      .debug_req_i(debug_req_i[h]),
      .eff_addr_o (eff_addr[h]),
      .mask_o     (mask[h]),
      .status_o   (status[h]),
      .rst_no     (hart_rst_no[h]),
      .boot_addr_o(hart_boot_addr_o[h]),
      .irq_o      (hart_irq_o[2*h+1:2*h]),
      .time_irq_o (hart_time_irq_o[h]),
      .ipi_o      (hart_ipi_o[h]),
      .debug_req_o(hart_debug_req_o[h])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hidx == 4'(h)) begin
        case (sel)
          2'd0:    rd_mux = eff_addr[h];
          2'd2:    rd_mux = {61'b0, mask[h]};
          2'd3:    rd_mux = {57'b0, status[h]};
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= reg_if.req;
      rdata_q <= (reg_if.req && !reg_if.we) ? rd_mux : '0;
    end
  end

  assign reg_if.ready = ready_q;
  assign reg_if.rdata = rdata_q;
endmodule

// File: tb/tb_cpu_cluster_ctrl.sv
module tb_cpu_cluster_ctrl;
  localparam int NH = 2;
  localparam int SS = 2;
  localparam int RD = 16;
`ifdef CPU_CLUSTER_IPI_EN
  localparam bit IPI = 1'b1;
`else
  localparam bit IPI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] boot_addr = 64'h8000_0000;
  logic [2*NH-1:0] irq = '0;
  logic [NH-1:0] tirq = '0, dbg = '0;

  logic [NH-1:0]       d_rst, d_tim, d_ipi, d_dbg;
  logic [2*NH-1:0]     d_irq;
  logic [NH-1:0][63:0] d_baddr;

  cpu_cluster_ctrl_if rif();

  cpu_cluster_ctrl #(.NUM_HARTS(NH), .SYNC_STAGES(SS), .RST_DLY(RD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .boot_addr_i(boot_addr), .reg_if(rif),
    .irq_i(irq), .time_irq_i(tirq), .debug_req_i(dbg),
    .hart_rst_no(d_rst), .hart_boot_addr_o(d_baddr), .hart_irq_o(d_irq),
    .hart_time_irq_o(d_tim), .hart_ipi_o(d_ipi), .hart_debug_req_o(d_dbg)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;

  // Behavioural model: a hart is RUN once RD edges have passed since the
  // edge it entered BOOT; async inputs appear SS+1 edges after sampling.
  int          e;
  int          m_state [NH];
  int          m_bedge [NH];
  logic [63:0] m_breg  [NH];
  bit          m_wr    [NH];
  logic [2:0]  m_mask  [NH];
  bit          m_pend  [NH];
  logic [63:0] m_bout  [NH];
  logic [3:0]  m_sh    [NH][SS];
  logic [2*NH-1:0] x_irq;
  logic [NH-1:0]   x_tim, x_dbg;
  logic            x_ready;
  logic [63:0]     x_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e = 0;
    for (int h = 0; h < NH; h++) begin
      m_state[h] = (h == 0) ? 1 : 0;
      m_bedge[h] = 1;
      m_breg[h]  = '0;
      m_wr[h]    = 0;
      m_mask[h]  = 3'b111;
      m_pend[h]  = 0;
      m_bout[h]  = (h == 0) ? boot_addr : 64'h0;
      for (int i = 0; i < SS; i++) m_sh[h][i] = '0;
    end
    x_irq = '0; x_tim = '0; x_dbg = '0; x_ready = 0; x_rdata = '0;
  endtask

  task automatic model_edge();
    logic [63:0] eff [NH];
    bit st [NH], hl [NH], ps [NH], pc [NH];
    logic [3:0] s;
    bit run;
    int hi, sl, prev;
    if (!rst_n) return;
    e++;
    for (int h = 0; h < NH; h++) begin
      run = (m_state[h] == 2);
      s = m_sh[h][SS-1];
      x_irq[2*h +: 2] = s[1:0] & m_mask[h][1:0] & {2{run}};
      x_tim[h] = s[2] & m_mask[h][2] & run;
      x_dbg[h] = s[3] & run;
      eff[h] = m_wr[h] ? m_breg[h] : boot_addr;
      st[h] = 0; hl[h] = 0; ps[h] = 0; pc[h] = 0;
    end
    hi = int'(rif.addr[7:4]);
    sl = int'(rif.addr[3:2]);
    x_ready = rif.req;
    x_rdata = '0;
    if (rif.req && hi < NH) begin
      s = m_sh[hi][SS-1];
      if (!rif.we) begin
        case (sl)
          0: x_rdata = eff[hi];
          2: x_rdata = 64'(m_mask[hi]);
          3: x_rdata = 64'(m_state[hi] + 4*int'(m_pend[hi]) + 8*int'(s[0]) +
                           16*int'(s[1]) + 32*int'(s[2]) + 64*int'(s[3]));
          default: x_rdata = '0;
        endcase
      end else begin
        case (sl)
          0: begin m_breg[hi] = rif.wdata; m_wr[hi] = 1; end
          1: begin
            st[hi] = rif.wdata[0]; hl[hi] = rif.wdata[1];
            ps[hi] = rif.wdata[2]; pc[hi] = rif.wdata[3];
          end
          2: m_mask[hi] = rif.wdata[2:0];
          default: ;
        endcase
      end
    end
    for (int h = 0; h < NH; h++) begin
      prev = m_state[h];
      if (hl[h] && !st[h] && prev != 0) m_state[h] = 0;
      else if (st[h] && (prev == 0 || (prev == 2 && hl[h]))) begin
        m_state[h] = 1; m_bedge[h] = e; m_bout[h] = eff[h];
      end else if (prev == 1 && e >= m_bedge[h] + RD) m_state[h] = 2;
      if (IPI) begin
        if (pc[h]) m_pend[h] = 0;
        else if (ps[h] && prev == 2) m_pend[h] = 1;
        if (m_state[h] != 2) m_pend[h] = 0;
      end
      for (int i = SS-1; i > 0; i--) m_sh[h][i] = m_sh[h][i-1];
      m_sh[h][0] = {dbg[h], tirq[h], irq[2*h+1], irq[2*h]};
    end
  endtask

  task automatic compare_all();
    logic [NH-1:0] xr, xp;
    for (int h = 0; h < NH; h++) begin
      xr[h] = (m_state[h] == 2);
      xp[h] = m_pend[h];
      chk("hart_boot_addr_o", d_baddr[h], m_bout[h]);
    end
    chk("hart_rst_no", 64'(d_rst), 64'(xr));
    chk("hart_irq_o", 64'(d_irq), 64'(x_irq));
    chk("hart_time_irq_o", 64'(d_tim), 64'(x_tim));
    chk("hart_debug_req_o", 64'(d_dbg), 64'(x_dbg));
    chk("hart_ipi_o", 64'(d_ipi), 64'(xp));
    chk("reg_ready_o", 64'(rif.ready), 64'(x_ready));
    if (x_ready) chk("reg_rdata_o", rif.rdata, x_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic acc(input bit w, input logic [7:0] a, input logic [63:0] d);
    rif.req = 1'b1; rif.we = w; rif.addr = a; rif.wdata = d;
    step();
    rif.req = 1'b0; rif.we = 1'b0;
  endtask

  initial begin
    rif.req = 1'b0; rif.we = 1'b0; rif.addr = '0; rif.wdata = '0;
    model_reset();
    step(); step();
    chk("reset_rst", 64'(d_rst), 64'h0);
    chk("reset_baddr0", d_baddr[0], 64'h8000_0000);
    rst_n = 1'b1;

    // reset release: hart 0 runs RD edges after the first edge
    repeat (16) step();
    chk("boot0_before", 64'(d_rst), 64'h0);
    step();
    chk("boot0_release", 64'(d_rst), 64'h1);
    acc(0, 8'h1C, 0);
    chk("h1_status_off", rif.rdata, 64'h0);
    chk("h1_status_ready", 64'(rif.ready), 64'h1);

    // hart 1 boot with a programmed address
    acc(1, 8'h10, 64'h8000_1000);
    acc(1, 8'h14, 64'h1);
    chk("h1_baddr", d_baddr[1], 64'h8000_1000);
    repeat (15) step();
    chk("h1_before", 64'(d_rst[1]), 64'h0);
    step();
    chk("h1_release", 64'(d_rst[1]), 64'h1);
    acc(0, 8'h1C, 0);
    chk("h1_status_run", rif.rdata, 64'h2);

    // interrupt latency and masking
    irq[1] = 1'b1; tirq[0] = 1'b1;
    step(); step();
    chk("irq_lat2", 64'(d_irq[1]), 64'h0);
    step();
    chk("irq_lat3", 64'(d_irq[1]), 64'h1);
    chk("tim_lat3", 64'(d_tim[0]), 64'h1);
    acc(1, 8'h08, 64'h5);
    step();
    chk("irq_masked", 64'(d_irq[1]), 64'h0);
    chk("tim_unmasked", 64'(d_tim[0]), 64'h1);
    acc(0, 8'h08, 0);
    chk("mask_read", rif.rdata, 64'h5);
    acc(0, 8'h0C, 0);
    chk("h0_status", rif.rdata, 64'h32);
    acc(0, 8'h04, 0);
    chk("ctrl_read", rif.rdata, 64'h0);
    dbg[1] = 1'b1;
    repeat (3) step();
    chk("dbg1", 64'(d_dbg[1]), 64'h1);

    // restart of hart 0 with irq0 live and an IPI pending
    acc(1, 8'h08, 64'h7);
    irq[0] = 1'b1;
    repeat (3) step();
    chk("irq0_on", 64'(d_irq[0]), 64'h1);
    acc(1, 8'h04, 64'h4);
    chk("ipi0_set", 64'(d_ipi[0]), 64'(IPI));
    acc(1, 8'h04, 64'h3);
    step();
    chk("restart_rst", 64'(d_rst[0]), 64'h0);
    chk("restart_irq", 64'(d_irq[0]), 64'h0);
    chk("restart_ipi", 64'(d_ipi[0]), 64'h0);
    repeat (14) step();
    chk("restart_before", 64'(d_rst[0]), 64'h0);
    step();
    chk("restart_release", 64'(d_rst[0]), 64'h1);

    // IPI set/clear on hart 1
    acc(1, 8'h14, 64'h4);
    chk("ipi1_set", 64'(d_ipi[1]), 64'(IPI));
    acc(0, 8'h1C, 0);
    chk("h1_status_ipi", rif.rdata, IPI ? 64'h46 : 64'h42);
    acc(1, 8'h14, 64'hC);
    chk("ipi1_clr", 64'(d_ipi[1]), 64'h0);

    // out-of-range hart index
    acc(1, 8'h50, 64'hDEAD_BEEF);
    acc(0, 8'h50, 0);
    chk("oor_rdata", rif.rdata, 64'h0);
    chk("oor_ready", 64'(rif.ready), 64'h1);

    // halt hart 1, IPI ignored while OFF
    acc(1, 8'h14, 64'h2);
    step();
    chk("halt_rst", 64'(d_rst[1]), 64'h0);
    chk("halt_dbg", 64'(d_dbg[1]), 64'h0);
    acc(0, 8'h1C, 0);
    chk("h1_status_halt", rif.rdata, 64'h40);
    acc(1, 8'h14, 64'h4);
    chk("ipi_off", 64'(d_ipi[1]), 64'h0);

    // START during BOOT does not restart the delay
    acc(1, 8'h14, 64'h1);
    repeat (5) step();
    acc(1, 8'h14, 64'h1);
    repeat (9) step();
    chk("reboot_before", 64'(d_rst[1]), 64'h0);
    step();
    chk("reboot_release", 64'(d_rst[1]), 64'h1);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("areset_rst", 64'(d_rst), 64'h0);
    chk("areset_baddr1", d_baddr[1], 64'h0);
    step(); step();
    rst_n = 1'b1;
    repeat (22) step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
